// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//   Instruction fetch front end. It keeps up to MAX_OUTSTANDING requests in
//   flight on an SRAM-like req/addr_ok/data_ok bus. Returned instructions go
//   into a FIFO_DEPTH-entry queue that feeds decode through valid/ready. A
//   redirect flushes the queue. Responses that are still in flight at that
//   point are counted in cancel_cnt and discarded when they arrive.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   inst_sram_*                fetch bus (read-only; write fields tied off)
//   redirect_valid/_pc         flush and restart fetch at redirect_pc
//   out_valid/out_ready        handshake toward decode
//   out_pc/out_inst/out_exc    head entry; out_exc flags a misaligned PC (ADEF)
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_exc
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } entry_t;

    // Fetch state
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          adef_stop_q, adef_stop_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] cancel_cnt_q, cancel_cnt_d;

    // In-flight PC queue: one slot per accepted request, in bus order
    logic [31:0]   ifq_pc_q [MAX_OUTSTANDING];
    logic [31:0]   ifq_pc_d [MAX_OUTSTANDING];
    logic [IW-1:0] ifq_wr_q, ifq_wr_d;
    logic [IW-1:0] ifq_rd_q, ifq_rd_d;

    // Instruction queue
    entry_t        fifo_q [FIFO_DEPTH];
    entry_t        fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic          pc_aligned;
    logic [SW-1:0] credit_used;
    logic          fifo_full;
    logic          accept;
    logic          resp_push;
    logic          adef_push;
    logic          push;
    logic          pop;
    entry_t        push_entry;

    function automatic logic [PW-1:0] fptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [IW-1:0] iptr_inc(input logic [IW-1:0] p);
        return (p == IW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Bus side. A request is only issued while a queue slot is reserved for
    // every response already in flight, so data_ok never has to stall.
    assign pc_aligned  = (fetch_pc_q[1:0] == 2'b00);
    assign credit_used = SW'(outstanding_q) + SW'(fifo_cnt_q);
    assign fifo_full   = (fifo_cnt_q == NW'(FIFO_DEPTH));

    assign inst_sram_req = ~reset & ~redirect_valid & ~adef_stop_q & pc_aligned
                         & (outstanding_q < CW'(MAX_OUTSTANDING))
                         & (credit_used < SW'(FIFO_DEPTH));
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_addr  = fetch_pc_q;
    assign inst_sram_wdata = 32'd0;

    assign accept = inst_sram_req & inst_sram_addr_ok;

    // A response enters the queue only if it belongs to the current stream.
    // In a redirect cycle the response is stale whatever cancel_cnt says.
    assign resp_push = inst_sram_data_ok & ~redirect_valid & (cancel_cnt_q == '0);

    // Misaligned PC: wait until the bus is quiet, then emit one ADEF marker
    // entry and stop fetching until a redirect.
    assign adef_push = ~pc_aligned & ~adef_stop_q & ~redirect_valid
                     & (outstanding_q == '0) & (cancel_cnt_q == '0) & ~fifo_full;

    assign push = resp_push | adef_push;

    // Decode side
    assign out_valid = (fifo_cnt_q != '0) & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign out_pc    = fifo_q[rd_ptr_q].pc;
    assign out_inst  = fifo_q[rd_ptr_q].inst;
    assign out_exc   = fifo_q[rd_ptr_q].exc;

    always_comb begin
        push_entry = '{pc: ifq_pc_q[ifq_rd_q], inst: inst_sram_rdata, exc: 1'b0};
        if (adef_push) begin
            push_entry = '{pc: fetch_pc_q, inst: 32'd0, exc: 1'b1};
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        cancel_cnt_d  = cancel_cnt_q;
        fetch_pc_d    = fetch_pc_q;
        adef_stop_d   = adef_stop_q;
        ifq_pc_d      = ifq_pc_q;
        ifq_wr_d      = ifq_wr_q;
        ifq_rd_d      = ifq_rd_q;
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;

        if (accept) begin
            ifq_pc_d[ifq_wr_q] = fetch_pc_q;
            ifq_wr_d           = iptr_inc(ifq_wr_q);
            outstanding_d      = outstanding_d + 1'b1;
            fetch_pc_d         = fetch_pc_q + 32'd4;
        end

        // Every response retires its in-flight slot, kept or dropped.
        if (inst_sram_data_ok) begin
            ifq_rd_d      = iptr_inc(ifq_rd_q);
            outstanding_d = outstanding_d - 1'b1;
            if (cancel_cnt_q != '0) begin
                cancel_cnt_d = cancel_cnt_q - 1'b1;
            end
        end

        if (push) begin
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d         = fptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = fptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        if (adef_push) begin
            adef_stop_d = 1'b1;
        end

        // Redirect wins over push/pop. Everything still on the bus after
        // this cycle is stale. Responses that were already cancelled are
        // still part of outstanding, so the new cancel count is simply the
        // remaining outstanding count, not an addition to the old one. This
        // keeps cancel_cnt <= outstanding across back-to-back redirects.
        if (redirect_valid) begin
            cancel_cnt_d = outstanding_d;
            fetch_pc_d   = redirect_pc;
            adef_stop_d  = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fifo_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            adef_stop_q   <= 1'b0;
            outstanding_q <= '0;
            cancel_cnt_q  <= '0;
            ifq_wr_q      <= '0;
            ifq_rd_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            adef_stop_q   <= adef_stop_d;
            outstanding_q <= outstanding_d;
            cancel_cnt_q  <= cancel_cnt_d;
            ifq_wr_q      <= ifq_wr_d;
            ifq_rd_q      <= ifq_rd_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // Payload storage carries no reset; validity lives in the counters.
    always_ff @(posedge clk) begin
        ifq_pc_q <= ifq_pc_d;
        fifo_q   <= fifo_d;
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok = 1'b0;
    logic        data_ok = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_inst;
    logic        out_exc;

    int errors = 0;
    int checks = 0;

    if_fetch_queue dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
        .inst_sram_wstrb(wstrb), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
        .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok),
        .inst_sram_rdata(rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_exc(out_exc)
    );

    always #5 clk = ~clk;

    // Bus model: accepted addresses answer in order, bus_dly edges after the
    // accept, with rdata = ~address. bus_hold freezes responses.
    typedef struct {
        logic [31:0] a;
        int          due;
    } bus_t;
    bus_t bq[$];
    bus_t be;
    int   edge_n = 0;
    int   bus_dly = 1;
    bit   bus_hold = 0;
    bit   bus_flush = 0;

    always @(posedge clk) begin
        if (bus_flush) bq.delete();
        else if (req && addr_ok) begin
            be.a = addr;
            be.due = edge_n + bus_dly;
            bq.push_back(be);
        end
        edge_n++;
        if (!bus_flush && !bus_hold && bq.size() > 0 && bq[0].due <= edge_n) begin
            data_ok <= 1'b1;
            rdata   <= ~bq[0].a;
            bq.pop_front();
        end else begin
            data_ok <= 1'b0;
            rdata   <= 32'd0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; bus_flush = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        out_ready = 1'b0; addr_ok = 1'b0; bus_hold = 1'b0; bus_dly = 1;
        repeat (2) @(negedge clk);
        reset = 1'b0; bus_flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus_flush = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (addr !== 32'h1c000000) begin errors++; $display("FAIL reset_pc: got %h want 1c000000", addr); end
        checks++;
        if (wr !== 1'b0 || size !== 2'b10 || wstrb !== 4'h0 || wdata !== 32'd0) begin
            errors++; $display("FAIL tie_offs: wr=%b size=%b wstrb=%h wdata=%h want 0/10/0/0", wr, size, wstrb, wdata);
        end
        reset = 1'b0; bus_flush = 1'b0;
        #1;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", req); end
        @(negedge clk);
        checks++; if (req !== 1'b1 || addr !== 32'h1c000000) begin
            errors++; $display("FAIL hold_addr: req=%b addr=%h want 1 1c000000", req, addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_a, exp_o;
        int n_out;
        bit over;
        do_reset();
        bus_dly = 2; addr_ok = 1'b1; out_ready = 1'b1;
        exp_a = 32'h1c000000; exp_o = 32'h1c000000; n_out = 0; over = 0;
        for (int c = 0; c < 80 && n_out < 8; c++) begin
            #1;
            if (req) begin
                checks++;
                if (addr !== exp_a) begin errors++; $display("FAIL stream_addr: got %h want %h", addr, exp_a); end
                exp_a += 32'd4;
            end
            if (bq.size() + int'(data_ok) > 2) over = 1;
            if (out_valid) begin
                checks++;
                if (out_pc !== exp_o || out_inst !== ~exp_o || out_exc !== 1'b0) begin
                    errors++; $display("FAIL stream_out: pc=%h inst=%h exc=%b want pc=%h inst=%h exc=0", out_pc, out_inst, out_exc, exp_o, ~exp_o);
                end
                exp_o += 32'd4; n_out++;
            end
            @(negedge clk);
        end
        checks++; if (n_out != 8) begin errors++; $display("FAIL stream_count: got %0d want 8", n_out); end
        checks++; if (over) begin errors++; $display("FAIL stream_outstanding: exceeded 2 want <=2"); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_o;
        int n_acc, n_out;
        do_reset();
        bus_dly = 1; addr_ok = 1'b1; out_ready = 1'b0; n_acc = 0;
        for (int c = 0; c < 20; c++) begin
            #1; if (req) n_acc++;
            @(negedge clk);
        end
        #1;
        checks++; if (n_acc != 4) begin errors++; $display("FAIL bp_accepts: got %0d want 4", n_acc); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b want 0", req); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1c000000) begin
            errors++; $display("FAIL bp_head: valid=%b pc=%h want 1 1c000000", out_valid, out_pc);
        end
        out_ready = 1'b1;
        exp_o = 32'h1c000000; n_out = 0;
        for (int c = 0; c < 60 && n_out < 10; c++) begin
            #1;
            if (out_valid) begin
                checks++;
                if (out_pc !== exp_o || out_inst !== ~exp_o) begin
                    errors++; $display("FAIL bp_drain: pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, exp_o, ~exp_o);
                end
                exp_o += 32'd4; n_out++;
            end
            @(negedge clk);
        end
        checks++; if (n_out != 10) begin errors++; $display("FAIL bp_drain_count: got %0d want 10", n_out); end
    endtask

    task automatic test_redirect();
        logic [31:0] exp_o;
        int n_out;
        do_reset();
        bus_dly = 1; bus_hold = 1'b1; addr_ok = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (req !== 1'b0 || bq.size() != 2) begin
            errors++; $display("FAIL rd_outstanding: req=%b inflight=%0d want 0 2", req, bq.size());
        end
        redirect_valid = 1'b1; redirect_pc = 32'h1c000100;
        @(negedge clk);
        redirect_valid = 1'b0; bus_hold = 1'b0;
        exp_o = 32'h1c000100; n_out = 0;
        for (int c = 0; c < 40 && n_out < 4; c++) begin
            #1;
            if (out_valid) begin
                checks++;
                if (out_pc !== exp_o || out_inst !== ~exp_o) begin
                    errors++; $display("FAIL rd_stream: pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, exp_o, ~exp_o);
                end
                exp_o += 32'd4; n_out++;
            end
            @(negedge clk);
        end
        checks++; if (n_out != 4) begin errors++; $display("FAIL rd_count: got %0d want 4", n_out); end
    endtask

    task automatic test_double_redirect();
        logic [31:0] exp_o;
        int n_out;
        do_reset();
        bus_dly = 1; bus_hold = 1'b1; addr_ok = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus_hold = 1'b0;
        @(negedge clk);
        // First redirect lands together with the first stale data_ok.
        redirect_valid = 1'b1; redirect_pc = 32'h1c000300; bus_hold = 1'b1;
        @(negedge clk);
        // Second redirect one cycle later, with no response that cycle.
        redirect_pc = 32'h1c000400;
        #1;
        checks++; if (out_valid !== 1'b0 || req !== 1'b0) begin
            errors++; $display("FAIL dr_during: valid=%b req=%b want 0 0", out_valid, req);
        end
        @(negedge clk);
        redirect_valid = 1'b0; bus_hold = 1'b0;
        #1;
        checks++; if (req !== 1'b1 || addr !== 32'h1c000400) begin
            errors++; $display("FAIL dr_refetch: req=%b addr=%h want 1 1c000400", req, addr);
        end
        exp_o = 32'h1c000400; n_out = 0;
        for (int c = 0; c < 40 && n_out < 4; c++) begin
            #1;
            if (out_valid) begin
                checks++;
                if (out_pc !== exp_o || out_inst !== ~exp_o) begin
                    errors++; $display("FAIL dr_stream: pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, exp_o, ~exp_o);
                end
                exp_o += 32'd4; n_out++;
            end
            @(negedge clk);
        end
        checks++; if (n_out != 4) begin errors++; $display("FAIL dr_count: got %0d want 4", n_out); end
    endtask

    task automatic test_adef();
        logic [31:0] exp_o;
        int n_req, n_out;
        do_reset();
        bus_dly = 1; addr_ok = 1'b1; out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h1c000102;
        @(negedge clk);
        redirect_valid = 1'b0; n_req = 0;
        for (int c = 0; c < 6; c++) begin
            #1; if (req) n_req++;
            @(negedge clk);
        end
        #1;
        checks++; if (n_req != 0) begin errors++; $display("FAIL adef_noreq: got %0d reqs want 0", n_req); end
        checks++;
        if (out_valid !== 1'b1 || out_exc !== 1'b1 || out_pc !== 32'h1c000102 || out_inst !== 32'd0) begin
            errors++; $display("FAIL adef_entry: valid=%b exc=%b pc=%h inst=%h want 1 1 1c000102 0", out_valid, out_exc, out_pc, out_inst);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || req !== 1'b0) begin
            errors++; $display("FAIL adef_single: valid=%b req=%b want 0 0", out_valid, req);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h1c000200;
        @(negedge clk);
        redirect_valid = 1'b0;
        exp_o = 32'h1c000200; n_out = 0;
        for (int c = 0; c < 40 && n_out < 3; c++) begin
            #1;
            if (out_valid) begin
                checks++;
                if (out_pc !== exp_o || out_inst !== ~exp_o || out_exc !== 1'b0) begin
                    errors++; $display("FAIL adef_resume: pc=%h inst=%h exc=%b want pc=%h inst=%h exc=0", out_pc, out_inst, out_exc, exp_o, ~exp_o);
                end
                exp_o += 32'd4; n_out++;
            end
            @(negedge clk);
        end
        checks++; if (n_out != 3) begin errors++; $display("FAIL adef_resume_count: got %0d want 3", n_out); end
    endtask

    task automatic test_reset_busy();
        do_reset();
        bus_dly = 1; addr_ok = 1'b1; out_ready = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || addr === 32'h1c000000) begin
            errors++; $display("FAIL rb_full: valid=%b addr=%h want 1 and addr past 1c000000", out_valid, addr);
        end
        // A redirect masks the head combinationally (pulse never sees an edge).
        redirect_valid = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rb_redirect_mask: got %b want 0", out_valid); end
        redirect_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1; bus_flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || req !== 1'b0 || addr !== 32'h1c000000) begin
            errors++; $display("FAIL rb_after_reset: valid=%b req=%b addr=%h want 0 0 1c000000", out_valid, req, addr);
        end
        reset = 1'b0; bus_flush = 1'b0;
        #1;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL rb_restart: req=%b want 1", req); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_double_redirect();
        test_adef();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
